// File: rtl/event_trailer_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : event_trailer_gen                                            |
// | Description : Registered pass-through for 23-bit readout words that        |
// |               appends one parity/count/overflow trailer after each event.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module event_trailer_gen #(
  parameter int CNT_W = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [22:0] in_data,
  input  logic        in_valid,
  input  logic        in_eoe,
  output logic        in_ready,
  output logic [22:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] event_count
);

  typedef enum logic [0:0] {
    S_DATA    = 1'b0,
    S_TRAILER = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [22:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [15:0]      event_count_q, event_count_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic slot_free;
  logic in_xfer;

  always_comb begin
    slot_free     = ~out_valid_q | out_ready;
    in_ready      = (state_q == S_DATA) & slot_free;
    in_xfer       = in_valid & in_ready;

    state_d       = state_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    event_count_d = event_count_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;

    case (state_q)
      S_DATA: begin
        if (in_xfer) begin
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          acc_d       = acc_q ^ (^in_data);
          // Saturate rather than wrap so the trailer never under-reports.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (in_eoe) begin
            state_d = S_TRAILER;
          end
        end else if (slot_free) begin
          out_valid_d = 1'b0;
        end
      end
      S_TRAILER: begin
        if (slot_free) begin
          out_data_d    = {acc_q, ovf_q, 21'(cnt_q)};
          out_valid_d   = 1'b1;
          out_last_d    = 1'b1;
          acc_d         = 1'b0;
          cnt_d         = '0;
          ovf_d         = 1'b0;
          event_count_d = event_count_q + 16'd1;
          state_d       = S_DATA;
        end
      end
      default: begin
        state_d = S_DATA;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_DATA;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      event_count_q <= '0;
      acc_q         <= 1'b0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      event_count_q <= event_count_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign event_count = event_count_q;

endmodule
`default_nettype wire

// File: tb/tb_event_trailer_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_event_trailer_gen                                         |
// | Description : Scoreboard bench for event_trailer_gen (CNT_W = 4).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_event_trailer_gen;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [22:0] in_data;
  logic        in_valid;
  logic        in_eoe;
  logic        in_ready;
  logic [22:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [15:0] event_count;

  int checks = 0;
  int errors = 0;

  // Expected output words: {last, data}
  logic [23:0] sb[$];

  always #5 clock = ~clock;

  event_trailer_gen #(.CNT_W(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_eoe     (in_eoe),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .event_count(event_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected word per output transfer, and checks stall stability.
  initial begin
    logic        prev_stall = 1'b0;
    logic [23:0] prev_word  = '0;
    logic [23:0] exp_w;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_word", 32'({out_last, out_data}), 32'(prev_word));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got 0x%0h expected nothing", {out_last, out_data});
          end else begin
            exp_w = sb.pop_front();
            check("out_word", 32'({out_last, out_data}), 32'(exp_w));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_last, out_data};
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send(input logic [22:0] d, input logic eoe, input logic [22:0] trl,
                      output int waits);
    in_valid = 1'b1;
    in_data  = d;
    in_eoe   = eoe;
    waits    = 0;
    @(negedge clock);
    while (!in_ready && waits < 100) begin
      @(posedge clock);
      #1;
      waits++;
      @(negedge clock);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready 0 expected 1 for data 0x%0h", d);
    end else begin
      sb.push_back({1'b0, d});
      if (eoe) sb.push_back({1'b1, trl});
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_eoe   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w;
    logic [22:0] held;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_eoe    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_event_count", 32'(event_count), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // One-word event with explicit one-cycle latency check.
    send(23'h000001, 1'b1, 23'h400001, w);
    @(negedge clock);
    check("lat_data", 32'(out_data), 32'h000001);
    check("lat_last", 32'(out_last), 32'd0);
    @(posedge clock);
    #1;
    drain();
    check("ec_one_word", 32'(event_count), 32'd1);

    // Three-word event; no input accepted while the trailer is loaded.
    send(23'h7FFFFF, 1'b0, 23'h0, w);
    send(23'h000003, 1'b0, 23'h0, w);
    send(23'h000007, 1'b1, 23'h000003, w);
    @(negedge clock);
    check("trailer_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    drain();
    check("ec_three_word", 32'(event_count), 32'd2);

    // Backpressure for 5 cycles mid-event.
    send(23'h123456, 1'b0, 23'h0, w);
    send(23'h00ABCD, 1'b0, 23'h0, w);
    held      = 23'h00ABCD;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 23'h7F0000;
    in_eoe    = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_data", 32'(out_data), 32'(held));
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    send(23'h7F0000, 1'b0, 23'h0, w);
    send(23'h000010, 1'b1, 23'h400004, w);
    drain();
    check("ec_backpressure", 32'(event_count), 32'd3);

    // Counter saturation: 17 words with CNT_W = 4.
    for (int i = 0; i < 17; i++) begin
      send(23'h000001, (i == 16), 23'h60000F, w);
    end
    drain();
    check("ec_overflow", 32'(event_count), 32'd4);

    // Back-to-back events with in_valid held high: one bubble per event.
    send(23'h000100, 1'b0, 23'h0, w);
    check("b2b_a0_waits", 32'(w), 32'd0);
    send(23'h000200, 1'b1, 23'h000002, w);
    check("b2b_a1_waits", 32'(w), 32'd0);
    send(23'h000300, 1'b1, 23'h000001, w);
    check("b2b_b0_waits", 32'(w), 32'd1);
    send(23'h000700, 1'b0, 23'h0, w);
    check("b2b_c0_waits", 32'(w), 32'd1);
    send(23'h000001, 1'b0, 23'h0, w);
    check("b2b_c1_waits", 32'(w), 32'd0);
    send(23'h000002, 1'b1, 23'h400003, w);
    check("b2b_c2_waits", 32'(w), 32'd0);
    drain();
    check("ec_b2b", 32'(event_count), 32'd7);

    // Reset two words into an event; partial event must be discarded.
    send(23'h000001, 1'b0, 23'h0, w);
    send(23'h000002, 1'b0, 23'h0, w);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_event_count", 32'(event_count), 32'd0);
    sb.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    send(23'h000004, 1'b1, 23'h400001, w);
    drain();
    check("ec_after_reset", 32'(event_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
